// File: rtl/data_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// access-size codes, controller states and the store byte-strobe helper.
package data_cache_ctrl_pkg;

    localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0;
    localparam logic [2:0] ACCESS_SZ_HALF = 3'd1;
    localparam logic [2:0] ACCESS_SZ_WORD = 3'd2;

    typedef enum logic [2:0] {
        DC_ST_IDLE,
        DC_ST_CMP,
        DC_ST_REFILL,
        DC_ST_WRITE,
        DC_ST_RESP
    } dc_state_e;

    // Unknown size codes fall back to a full-word strobe.
    function automatic logic [3:0] store_strobe(input logic [2:0] sz, input logic [1:0] lane);
        case (sz)
            ACCESS_SZ_BYTE: return 4'b0001 << lane;
            ACCESS_SZ_HALF: return 4'b0011 << {lane[1], 1'b0};
            default:        return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Cache data array: one RAM per word of the line, whole-line registered read,
// single-word write with per-byte enables.
module dcache_line_ram #(
    parameter int INDEX_BITS = 6,
    parameter int WORD_BITS  = 2
) (
    input  logic                          clk,
    input  logic [INDEX_BITS-1:0]         i_rd_index,
    output logic [(32<<WORD_BITS)-1:0]    o_rd_line,
    input  logic                          i_wr_en,
    input  logic [INDEX_BITS-1:0]         i_wr_index,
    input  logic [WORD_BITS-1:0]          i_wr_word,
    input  logic [3:0]                    i_wr_be,
    input  logic [31:0]                   i_wr_data
);
    localparam int LINE_WORDS = 1 << WORD_BITS;
    localparam int SETS       = 1 << INDEX_BITS;

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            logic [31:0] r_mem [SETS];
            logic [31:0] r_rd_word;
            logic        w_sel;

            assign w_sel = i_wr_en && (i_wr_word == WORD_BITS'(gi));

            always_ff @(posedge clk) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_sel && i_wr_be[b]) begin
                        r_mem[i_wr_index][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                    end
                end
                r_rd_word <= r_mem[i_rd_index];
            end

            assign o_rd_line[gi*32 +: 32] = r_rd_word;
        end
    endgenerate

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Arrays are read with the incoming index; the tag compare happens in CMP.
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic [31:0] raddr,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic [2:0]  access_sz,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rlast,
    input  logic        mem_bvalid
);
    localparam int TAG_BITS   = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int WORD_BITS  = OFFSET_BITS - 2;
    localparam int LINE_WORDS = 1 << WORD_BITS;
    localparam int SETS       = 1 << INDEX_BITS;

    dc_state_e r_state, w_state_next;

    logic [31:0]           r_addr, r_wdata, r_rdata_cap;
    logic [2:0]            r_sz;
    logic                  r_is_store, r_store_hit, r_req_pending;
    logic [WORD_BITS-1:0]  r_beat;
    logic [SETS-1:0]       r_valid;
    logic [TAG_BITS-1:0]   r_tag_mem [SETS];
    logic [TAG_BITS-1:0]   r_tag_rd;
    logic                  r_valid_rd;

    logic [INDEX_BITS-1:0]      w_rd_index, w_index;
    logic [TAG_BITS-1:0]        w_tag;
    logic [WORD_BITS-1:0]       w_word;
    logic [32*LINE_WORDS-1:0]   w_rd_line;
    logic [31:0]                w_line_word, w_store_data;
    logic [3:0]                 w_strobe;
    logic w_lookup_hit, w_load_hit, w_can_accept, w_accept;
    logic w_beat_valid, w_last, w_store_done;

    assign w_rd_index   = we ? waddr[OFFSET_BITS +: INDEX_BITS] : raddr[OFFSET_BITS +: INDEX_BITS];
    assign w_tag        = r_addr[31 -: TAG_BITS];
    assign w_index      = r_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_word       = r_addr[OFFSET_BITS-1:2];
    assign w_line_word  = w_rd_line[w_word*32 +: 32];
    assign w_store_data = r_wdata << {r_addr[1:0], 3'b000};
    assign w_strobe     = store_strobe(r_sz, r_addr[1:0]);

    assign w_lookup_hit = r_valid_rd && (r_tag_rd == w_tag);
    assign w_load_hit   = (r_state == DC_ST_CMP) && !r_is_store && w_lookup_hit;
    assign w_can_accept = (r_state == DC_ST_IDLE) || (r_state == DC_ST_RESP) || w_load_hit;
    assign w_accept     = w_can_accept && (re || we);

    // Memory responses only count once the request has been granted, so
    // beats left over from a transaction abandoned by reset are dropped.
    assign w_beat_valid = (r_state == DC_ST_REFILL) && !r_req_pending && mem_rvalid;
    assign w_last       = w_beat_valid && mem_rlast;
    assign w_store_done = (r_state == DC_ST_WRITE) && !r_req_pending && mem_bvalid;

    dcache_line_ram #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS)
    ) u_line_ram (
        .clk        (clk),
        .i_rd_index (w_rd_index),
        .o_rd_line  (w_rd_line),
        .i_wr_en    (w_beat_valid || (w_store_done && r_store_hit)),
        .i_wr_index (w_index),
        .i_wr_word  (w_beat_valid ? r_beat : w_word),
        .i_wr_be    (w_beat_valid ? 4'b1111 : w_strobe),
        .i_wr_data  (w_beat_valid ? mem_rdata : w_store_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DC_ST_IDLE;
        end else begin
            r_state <= w_state_next;
            if (w_can_accept) begin
                assert (!(re && we));
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        hit          = 1'b1;
        rdata        = r_rdata_cap;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        case (r_state)
            DC_ST_IDLE: begin
                if (re || we) w_state_next = DC_ST_CMP;
            end
            DC_ST_CMP: begin
                if (r_is_store) begin
                    hit          = 1'b0;
                    w_state_next = DC_ST_WRITE;
                end else if (w_lookup_hit) begin
                    rdata        = w_line_word;
                    w_state_next = (re || we) ? DC_ST_CMP : DC_ST_IDLE;
                end else begin
                    hit          = 1'b0;
                    w_state_next = DC_ST_REFILL;
                end
            end
            DC_ST_REFILL: begin
                hit      = 1'b0;
                mem_req  = r_req_pending;
                mem_addr = {r_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                if (w_last) w_state_next = DC_ST_RESP;
            end
            DC_ST_WRITE: begin
                hit       = 1'b0;
                mem_req   = r_req_pending;
                mem_we    = 1'b1;
                mem_addr  = {r_addr[31:2], 2'b00};
                mem_wdata = w_store_data;
                mem_wstrb = w_strobe;
                if (w_store_done) w_state_next = DC_ST_RESP;
            end
            DC_ST_RESP: begin
                w_state_next = (re || we) ? DC_ST_CMP : DC_ST_IDLE;
            end
            default: w_state_next = DC_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        r_tag_rd <= r_tag_mem[w_rd_index];
        if (w_last) r_tag_mem[w_index] <= w_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_valid_rd    <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_sz          <= '0;
            r_is_store    <= 1'b0;
            r_store_hit   <= 1'b0;
            r_req_pending <= 1'b0;
            r_beat        <= '0;
            r_rdata_cap   <= '0;
        end else begin
            r_valid_rd <= r_valid[w_rd_index];
            if (w_accept) begin
                r_is_store <= we;
                r_addr     <= we ? waddr : raddr;
                r_wdata    <= wdata;
                r_sz       <= access_sz;
            end
            if ((r_state == DC_ST_CMP) && (r_is_store || !w_lookup_hit)) begin
                r_req_pending <= 1'b1;
                r_beat        <= '0;
                r_store_hit   <= w_lookup_hit;
            end else if (mem_gnt) begin
                r_req_pending <= 1'b0;
            end
            if (w_beat_valid) begin
                r_beat <= r_beat + 1'b1;
                if (r_beat == w_word) r_rdata_cap <= mem_rdata;
            end
            if (w_last) r_valid[w_index] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: the bench plays the memory side cycle by
// cycle and checks hit/rdata/memory-port values against hand-computed numbers.
module tb_data_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst, re, we;
    logic [31:0] raddr, waddr, wdata;
    logic [2:0]  access_sz;
    logic [31:0] rdata;
    logic        hit;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid, mem_rlast, mem_bvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_cache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .re         (re),
        .raddr      (raddr),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .access_sz  (access_sz),
        .rdata      (rdata),
        .hit        (hit),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rlast  (mem_rlast),
        .mem_bvalid (mem_bvalid)
    );

    // Drive point: just after the active edge. Check point: the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] check %s observed %h expected %h", tag, obs, exp);
    endtask

    // Called in a CMP-miss cycle; returns at the drive point of the RESP cycle.
    task automatic refill(input string tag, input logic [31:0] line_addr,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
        step(); mem_gnt = 1'b1;
        settle();
        chk({tag, "_req"},  32'(mem_req), 32'd1);
        chk({tag, "_we"},   32'(mem_we),  32'd0);
        chk({tag, "_addr"}, mem_addr, line_addr);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d0;
        settle();
        chk({tag, "_req_drop"}, 32'(mem_req), 32'd0);
        chk({tag, "_busy"},     32'(hit),     32'd0);
        step(); mem_rdata = d1;
        step(); mem_rdata = d2;
        step(); mem_rdata = d3; mem_rlast = 1'b1;
        step(); mem_rvalid = 1'b0; mem_rlast = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0;
        raddr = '0; waddr = '0; wdata = '0; access_sz = 3'd2;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0; mem_bvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then load 0x104 (miss + refill)
        re = 1'b1; raddr = 32'h104;
        settle();
        chk("rst_hit",   32'(hit), 32'd1);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_addr",  mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'h0);
        step(); settle();
        chk("ld104_miss", 32'(hit), 32'd0);
        refill("ld104", 32'h100, 32'h11, 32'h22, 32'h33, 32'h44);
        settle();
        chk("ld104_resp_hit",   32'(hit), 32'd1);
        chk("ld104_resp_rdata", rdata, 32'h22);
        step(); re = 1'b0;
        settle();
        chk("ld104_rep_hit",   32'(hit), 32'd1);
        chk("ld104_rep_rdata", rdata, 32'h22);
        chk("ld104_rep_noreq", 32'(mem_req), 32'd0);

        // Byte store 0xAB to 0x106 (line resident), then load 0x104 back-to-back
        step(); we = 1'b1; waddr = 32'h106; wdata = 32'hAB; access_sz = 3'd0;
        settle();
        step(); settle();
        chk("st106_busy", 32'(hit), 32'd0);
        step(); mem_gnt = 1'b1;
        settle();
        chk("st106_req",   32'(mem_req), 32'd1);
        chk("st106_we",    32'(mem_we), 32'd1);
        chk("st106_addr",  mem_addr, 32'h104);
        chk("st106_wstrb", 32'(mem_wstrb), 32'h4);
        chk("st106_wdata", mem_wdata, 32'h00AB_0000);
        step(); mem_gnt = 1'b0; mem_bvalid = 1'b1;
        settle();
        chk("st106_req_drop", 32'(mem_req), 32'd0);
        step(); mem_bvalid = 1'b0; we = 1'b0; re = 1'b1; raddr = 32'h104;
        settle();
        chk("st106_resp_hit", 32'(hit), 32'd1);
        step(); re = 1'b0;
        settle();
        chk("ld104_merged_hit",   32'(hit), 32'd1);
        chk("ld104_merged_rdata", rdata, 32'h00AB_0022);

        // Half store 0xBEEF to 0x2002 (line absent): no allocate
        step(); we = 1'b1; waddr = 32'h2002; wdata = 32'hBEEF; access_sz = 3'd1;
        settle();
        step(); settle();
        chk("st2002_busy", 32'(hit), 32'd0);
        step(); mem_gnt = 1'b1;
        settle();
        chk("st2002_addr",  mem_addr, 32'h2000);
        chk("st2002_wstrb", 32'(mem_wstrb), 32'hC);
        chk("st2002_wdata", mem_wdata, 32'hBEEF_0000);
        step(); mem_gnt = 1'b0; mem_bvalid = 1'b1;
        step(); mem_bvalid = 1'b0; we = 1'b0;
        settle();
        chk("st2002_resp_hit", 32'(hit), 32'd1);
        step(); re = 1'b1; raddr = 32'h2000;
        settle();
        step(); settle();
        chk("ld2000_miss", 32'(hit), 32'd0);
        refill("ld2000", 32'h2000, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        re = 1'b0;
        settle();
        chk("ld2000_resp_hit",   32'(hit), 32'd1);
        chk("ld2000_resp_rdata", rdata, 32'hA0);

        // Back-to-back hits 0x100, 0x108, 0x10C
        step(); re = 1'b1; raddr = 32'h100;
        settle();
        step(); raddr = 32'h108;
        settle();
        chk("b2b0_hit",   32'(hit), 32'd1);
        chk("b2b0_rdata", rdata, 32'h11);
        step(); raddr = 32'h10C;
        settle();
        chk("b2b1_hit",   32'(hit), 32'd1);
        chk("b2b1_rdata", rdata, 32'h33);
        step(); re = 1'b0;
        settle();
        chk("b2b2_hit",   32'(hit), 32'd1);
        chk("b2b2_rdata", rdata, 32'h44);

        // Conflict: 0x500 evicts 0x100
        step(); re = 1'b1; raddr = 32'h500;
        settle();
        step(); settle();
        chk("ld500_miss", 32'(hit), 32'd0);
        refill("ld500", 32'h500, 32'h51, 32'h52, 32'h53, 32'h54);
        raddr = 32'h100;
        settle();
        chk("ld500_resp_hit",   32'(hit), 32'd1);
        chk("ld500_resp_rdata", rdata, 32'h51);
        step(); settle();
        chk("ld100_evicted_miss", 32'(hit), 32'd0);
        refill("ld100b", 32'h100, 32'h11, 32'h22, 32'h33, 32'h44);
        re = 1'b0;
        settle();
        chk("ld100b_resp_rdata", rdata, 32'h11);

        // Reset during the 2nd beat of a refill
        step(); re = 1'b1; raddr = 32'h300;
        settle();
        step(); settle();
        chk("ld300_miss", 32'(hit), 32'd0);
        step(); mem_gnt = 1'b1;
        settle();
        chk("ld300_req", 32'(mem_req), 32'd1);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h61;
        step(); mem_rdata = 32'h62; rst = 1'b1;
        step(); rst = 1'b0; re = 1'b0; mem_rdata = 32'h63;
        settle();
        chk("rst_mid_hit",   32'(hit), 32'd1);
        chk("rst_mid_req",   32'(mem_req), 32'd0);
        chk("rst_mid_rdata", rdata, 32'h0);
        step(); mem_rdata = 32'h64; mem_rlast = 1'b1;
        settle();
        chk("rst_stale_hit", 32'(hit), 32'd1);
        chk("rst_stale_req", 32'(mem_req), 32'd0);
        step(); mem_rvalid = 1'b0; mem_rlast = 1'b0; re = 1'b1; raddr = 32'h100;
        settle();
        step(); settle();
        chk("ld100_after_rst_miss", 32'(hit), 32'd0);
        refill("ld100c", 32'h100, 32'h71, 32'h72, 32'h73, 32'h74);
        re = 1'b0;
        settle();
        chk("ld100c_resp_hit",   32'(hit), 32'd1);
        chk("ld100c_resp_rdata", rdata, 32'h71);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
